mux16_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-to-1 bit-select datapath among 16 requesters. It registers the winning requester's index as the mux select and presents the selected bit downstream with a valid/ready handshake. It returns a one-cycle acknowledge to the winner. It sits directly in front of the 16:1 mux tree and owns its select lines.

---
 rtl/mux16_arb_pkg.sv | 20 ++
 rtl/mux16.sv | 10 +
 rtl/mux16_rr_arbiter_rr_pick16.sv | 28 ++
 rtl/mux16_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux16_rr_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mux16_arb_pkg.sv
// Shared types and helpers for the 16-way round-robin mux arbiter.
// Optional burst mode is selected elsewhere by MUX16_ARB_BURST_EN.
package mux16_arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux16.sv
// 16:1 single-bit mux tree driven by the arbiter's registered select.
module mux16 (
  input  logic [15:0] a,
  input  logic [3:0]  s,
  output logic        y
);

  assign y = a[s];

endmodule

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Combinational round-robin picker: first set bit at or above ptr, wrapping 15->0.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  // Rotate so that bit 0 of rot corresponds to candidate ptr.
  assign dbl = {cand, cand} >> ptr;
  assign rot = dbl[N_REQ-1:0];
  assign any = |cand;

  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the select of a 16:1 bit mux, with valid/ready output.
// Define MUX16_ARB_BURST_EN to let a winner keep the grant for up to BURST_LEN beats.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ack
);

  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
    $error("BURST_LEN must be in 1..16");
  end

  state_t           state_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] out_sel_reg;

  logic             busy;
  logic             handshake;
  logic             burst_hold;
  logic             rearb;
  logic [N_REQ-1:0] sel_oh;
  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  assign busy      = (state_reg == ST_BUSY);
  assign handshake = busy & out_ready;
  assign sel_oh    = idx_to_onehot(out_sel_reg);

  // One picker serves both paths: raw req from ptr in IDLE, masked req from
  // the slot after the current winner on a handshake.
  assign cand     = busy ? (req & ~sel_oh) : req;
  assign pick_ptr = busy ? out_sel_reg + SEL_W'(1) : ptr_reg;

  rr_pick16 u_pick (
    .cand (cand),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef MUX16_ARB_BURST_EN
  logic [SEL_W-1:0] beat_cnt_reg;

  assign burst_hold = req[out_sel_reg] && (int'(beat_cnt_reg) < BURST_LEN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE || rearb) begin
      beat_cnt_reg <= '0;
    end else if (handshake) begin
      beat_cnt_reg <= beat_cnt_reg + SEL_W'(1);
    end
  end
`else
  assign burst_hold = 1'b0;
`endif

  assign rearb = handshake & ~burst_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      out_sel_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            out_sel_reg <= pick_idx;
            state_reg   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The grant is held through backpressure even if req drops.
          if (rearb) begin
            ptr_reg <= out_sel_reg + SEL_W'(1);
            if (pick_any) begin
              out_sel_reg <= pick_idx;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  mux16 u_mux (
    .a (din),
    .s (out_sel_reg),
    .y (out_data)
  );

  assign out_valid = busy;
  assign out_sel   = out_sel_reg;
  assign grant     = busy ? sel_oh : '0;
  assign ack       = grant & {N_REQ{out_ready}};

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Table-driven bench for mux16_rr_arbiter with an expected-result queue.
module tb_mux16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] din;
  logic        out_ready;
  logic        out_valid;
  logic        out_data;
  logic [3:0]  out_sel;
  logic [15:0] grant;
  logic [15:0] ack;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .grant     (grant),
    .ack       (ack)
  );

  typedef struct {
    bit          rst_before;
    logic [15:0] req;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_sel;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [3:0]  sel;
    logic        data;
    logic [15:0] grant;
    logic [15:0] ack;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic void add(bit r, logic [15:0] rq, logic rdy, logic v, logic [3:0] s);
    vec_t t;
    t.rst_before = r;
    t.req        = rq;
    t.rdy        = rdy;
    t.exp_valid  = v;
    t.exp_sel    = s;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    din = '0;
    out_ready = 1'b0;
    #1;
    chk("reset out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset out_sel", {12'd0, out_sel}, 16'd0);
    chk("reset grant", grant, 16'd0);
    chk("reset ack", ack, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs, queue the expected outputs, then compare mid-cycle.
  task automatic apply(input vec_t v, input int n);
    exp_t        e;
    exp_t        got;
    logic [15:0] one;
    one = 16'h0001;
    din = 16'($urandom);
    req = v.req;
    out_ready = v.rdy;
    e.valid = v.exp_valid;
    e.sel   = v.exp_sel;
    e.grant = v.exp_valid ? (one << v.exp_sel) : 16'h0000;
    e.ack   = e.grant & {16{v.rdy}};
    e.data  = din[v.exp_sel];
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    $display("txn %0d req=%h rdy=%0d valid=%0d sel=%0d grant=%h ack=%h",
             n, req, out_ready, out_valid, out_sel, grant, ack);
    chk($sformatf("v%0d out_valid", n), {15'd0, out_valid}, {15'd0, got.valid});
    chk($sformatf("v%0d grant", n), grant, got.grant);
    chk($sformatf("v%0d ack", n), ack, got.ack);
    if (got.valid) begin
      chk($sformatf("v%0d out_sel", n), {12'd0, out_sel}, {12'd0, got.sel});
      chk($sformatf("v%0d out_data", n), {15'd0, out_data}, {15'd0, got.data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_full;
    vec_t v;
    rst_n = 1'b0;
    req = '0;
    din = '0;
    out_ready = 1'b0;

    // Single request, then a pointer probe: after winner 5, requester 6 beats 0.
    add(1, 16'h0020, 1, 0, 0);
    add(0, 16'h0000, 1, 1, 5);
    add(0, 16'h0041, 1, 0, 0);
    add(0, 16'h0001, 1, 1, 6);
    add(0, 16'h0000, 1, 1, 0);
    add(0, 16'h0000, 1, 0, 0);

    // Full contention: one beat per cycle, no bubbles.
    add(1, 16'hFFFF, 1, 0, 0);
`ifdef MUX16_ARB_BURST_EN
    n_full = 68;
    for (int i = 0; i < n_full; i++) add(0, 16'hFFFF, 1, 1, 4'((i / 4) % 16));
`else
    n_full = 17;
    for (int i = 0; i < n_full; i++) add(0, 16'hFFFF, 1, 1, 4'(i % 16));
`endif

    // Backpressure: five stalled cycles, then release.
    add(1, 16'h0101, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 16'h0101, 0, 1, 0);
    add(0, 16'h0100, 1, 1, 0);
    add(0, 16'h0000, 1, 1, 8);
    add(0, 16'h0000, 1, 0, 0);

    // Wrap-around from ptr=14.
    add(1, 16'h2000, 1, 0, 0);
    add(0, 16'h0000, 1, 1, 13);
    add(0, 16'h0003, 1, 0, 0);
    add(0, 16'h0002, 1, 1, 0);
    add(0, 16'h0000, 1, 1, 1);
    add(0, 16'h0000, 1, 0, 0);

    // Two requesters held high.
    add(1, 16'h0011, 1, 0, 0);
`ifdef MUX16_ARB_BURST_EN
    for (int i = 0; i < 9; i++) add(0, 16'h0011, 1, 1, ((i / 4) % 2 != 0) ? 4'd4 : 4'd0);
`else
    for (int i = 0; i < 5; i++) add(0, 16'h0011, 1, 1, ((i % 2) != 0) ? 4'd4 : 4'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      apply(vecs[i], i);
    end

    // Reset while BUSY on requester 9 with backpressure.
    do_reset();
    req = 16'h0200;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy valid", {15'd0, out_valid}, 16'd1);
    chk("midrst busy sel", {12'd0, out_sel}, 16'd9);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn midrst valid=%0d grant=%h ack=%h", out_valid, grant, ack);
    chk("midrst out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst grant", grant, 16'd0);
    chk("midrst ack", ack, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = '{rst_before: 1'b0, req: 16'hFFFF, rdy: 1'b1, exp_valid: 1'b0, exp_sel: 4'd0};
    apply(v, 1000);
    v = '{rst_before: 1'b0, req: 16'h0000, rdy: 1'b1, exp_valid: 1'b1, exp_sel: 4'd0};
    apply(v, 1001);
    v = '{rst_before: 1'b0, req: 16'h0000, rdy: 1'b1, exp_valid: 1'b0, exp_sel: 4'd0};
    apply(v, 1002);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
